// File: rtl/map_ss_seq_if.sv
// rtl/map_ss_seq_if.sv - control, save-state bus and byte streams of the mapper save/load sequencer
interface map_ss_seq_if;
  logic       start;
  logic       mode;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] out_dat;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] in_dat;
  logic       in_vld;
  logic       in_rdy;

  modport master (
    input  start, mode, abort, ss_rdat, out_rdy, in_dat, in_vld,
    output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, out_dat, out_vld, in_rdy
  );

  modport slave (
    output start, mode, abort, ss_rdat, out_rdy, in_dat, in_vld,
    input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, out_dat, out_vld, in_rdy
  );
endinterface

// File: rtl/map_ss_seq.sv
// rtl/map_ss_seq.sv - mapper save-state sequencer: streams index byte plus register bytes out, or verifies and writes them back
module map_ss_seq #(
  parameter int REG_CNT  = 5,
  parameter int IDX_ADDR = 127,
  parameter int SETTLE   = 2
) (
  input logic          clk,
  input logic          rst,
  map_ss_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, ARM, RD, PUSH, POP, WR, FIN} state_t;

  localparam logic [7:0] LAST  = 8'(REG_CNT);
  localparam logic [7:0] IDX_A = 8'(IDX_ADDR);

  state_t     state;
  logic [3:0] settle;
  logic [7:0] idx;
  logic       mode_r;
  logic       busy_r, done_r, err_r, act_r, we_r, vld_r, rdy_r;
  logic [7:0] addr_r, wdat_r, odat_r;

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.ss_act  = act_r;
  assign bus.ss_we   = we_r;
  assign bus.ss_addr = addr_r;
  assign bus.ss_wdat = wdat_r;
  assign bus.out_dat = odat_r;
  assign bus.out_vld = vld_r;
  assign bus.in_rdy  = rdy_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      settle <= 4'd0;
      idx    <= 8'd0;
      mode_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      act_r  <= 1'b0;
      we_r   <= 1'b0;
      vld_r  <= 1'b0;
      rdy_r  <= 1'b0;
      addr_r <= 8'd0;
      wdat_r <= 8'd0;
      odat_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      // abort beats any handshake in the same cycle: the byte is treated as not transferred
      if (state != IDLE && bus.abort) begin
        state  <= IDLE;
        err_r  <= 1'b1;
        busy_r <= 1'b0;
        act_r  <= 1'b0;
        we_r   <= 1'b0;
        vld_r  <= 1'b0;
        rdy_r  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            act_r  <= 1'b1;
            mode_r <= bus.mode;
            settle <= 4'(SETTLE);
            state  <= ARM;
          end
          ARM: if (settle == 4'd1) begin
            idx    <= 8'd0;
            addr_r <= IDX_A;
            if (mode_r) begin
              rdy_r <= 1'b1;
              state <= POP;
            end else begin
              state <= RD;
            end
          end else begin
            settle <= settle - 4'd1;
          end
          RD: begin
            odat_r <= bus.ss_rdat;
            vld_r  <= 1'b1;
            state  <= PUSH;
          end
          PUSH: if (bus.out_rdy) begin
            vld_r <= 1'b0;
            if (idx == LAST) begin
              done_r <= 1'b1;
              state  <= FIN;
            end else begin
              addr_r <= idx;
              idx    <= idx + 8'd1;
              state  <= RD;
            end
          end
          POP: if (!rdy_r) begin
            rdy_r <= 1'b1;
          end else if (bus.in_vld) begin
            rdy_r <= 1'b0;
            if (idx == 8'd0) begin
              // the index byte must match the live mapper before anything is written
              if (bus.in_dat != bus.ss_rdat) begin
                err_r  <= 1'b1;
                busy_r <= 1'b0;
                act_r  <= 1'b0;
                state  <= IDLE;
              end else begin
                idx <= 8'd1;
              end
            end else begin
              addr_r <= idx - 8'd1;
              wdat_r <= bus.in_dat;
              we_r   <= 1'b1;
              state  <= WR;
            end
          end
          WR: begin
            we_r <= 1'b0;
            if (idx == LAST) begin
              done_r <= 1'b1;
              state  <= FIN;
            end else begin
              idx   <= idx + 8'd1;
              rdy_r <= 1'b1;
              state <= POP;
            end
          end
          FIN: begin
            busy_r <= 1'b0;
            act_r  <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
